// File: rtl/power_seq_if.sv
// Signal bundle between the G-15 power-up sequencer (master) and the core/reader side (slave).
// Contract: tick_ms is a one-clk pulse, start acts on its rising edge, abort is a level, and all outputs are registered.
interface power_seq_if;
  logic       tick_ms;
  logic       start;
  logic       abort;
  logic       PL6_18_WAIT_FOR_TAPE;
  logic       PWR_CLEAR;
  logic       PWR_NO_CLEAR;
  logic       PWR_OP;
  logic       PWR_NO_OP;
  logic       PWR_AUTO_TAPE_START;
  logic       PWR_NT;
  logic       SW_GO;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] phase;

  modport master (
    input  tick_ms, start, abort, PL6_18_WAIT_FOR_TAPE,
    output PWR_CLEAR, PWR_NO_CLEAR, PWR_OP, PWR_NO_OP, PWR_AUTO_TAPE_START,
    output PWR_NT, SW_GO, busy, done, fault, phase
  );

  modport slave (
    output tick_ms, start, abort, PL6_18_WAIT_FOR_TAPE,
    input  PWR_CLEAR, PWR_NO_CLEAR, PWR_OP, PWR_NO_OP, PWR_AUTO_TAPE_START,
    input  PWR_NT, SW_GO, busy, done, fault, phase
  );
endinterface

// File: rtl/power_seq.sv
// Power-up sequencer for the G-15 core: clear, OP pulse, timing-track read-in,
// number-track transfer, loader read-in, then GO. Time base is the tick_ms pulse.
module power_seq #(
  parameter int T_CLEAR   = 150,
  parameter int T_OP_PRE  = 30,
  parameter int T_OP      = 60,
  parameter int T_OP_POST = 30,
  parameter int T_SETTLE  = 120,
  parameter int T_ATS     = 30,
  parameter int T_NT      = 120,
  parameter int T_TAPE_TO = 60000,
  parameter int CW        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  power_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_OPPRE  = 4'd2,
    S_OP     = 4'd3,
    S_OPPOST = 4'd4,
    S_SET1   = 4'd5,
    S_ATS1   = 4'd6,
    S_WTT    = 4'd7,
    S_SET2   = 4'd8,
    S_NT     = 4'd9,
    S_SET3   = 4'd10,
    S_ATS2   = 4'd11,
    S_WLD    = 4'd12,
    S_SET4   = 4'd13,
    S_GO     = 4'd14,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [CW-1:0] L_CLEAR   = CW'(T_CLEAR - 1);
  localparam logic [CW-1:0] L_OP_PRE  = CW'(T_OP_PRE - 1);
  localparam logic [CW-1:0] L_OP      = CW'(T_OP - 1);
  localparam logic [CW-1:0] L_OP_POST = CW'(T_OP_POST - 1);
  localparam logic [CW-1:0] L_SETTLE  = CW'(T_SETTLE - 1);
  localparam logic [CW-1:0] L_ATS     = CW'(T_ATS - 1);
  localparam logic [CW-1:0] L_NT      = CW'(T_NT - 1);
  localparam logic [CW-1:0] L_TAPE_TO = CW'(T_TAPE_TO - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic          count_done;
  logic [1:0]    rst_pipe;
  logic          rst_sync_n;
  logic          tape_meta;
  logic          tape_sync;
  logic          tape_sync_d;
  logic          tape_fall;
  logic          fall_seen;
  logic          fall_watch;
  logic          entering_ats;
  logic          start_d;
  logic          start_rise;

  logic clear_d, op_d, no_op_d, ats_d, nt_d, go_d, busy_d, done_d, fault_d;
  logic clear_q, no_clear_q, op_q, no_op_q, ats_q, nt_q, go_q, busy_q, done_q, fault_q;
  logic [3:0] phase_q;

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tape_meta   <= 1'b0;
      tape_sync   <= 1'b0;
      tape_sync_d <= 1'b0;
      start_d     <= 1'b0;
    end else begin
      tape_meta   <= bus.PL6_18_WAIT_FOR_TAPE;
      tape_sync   <= tape_meta;
      tape_sync_d <= tape_sync;
      start_d     <= bus.start;
    end
  end

  assign tape_fall  = tape_sync_d & ~tape_sync;
  assign start_rise = bus.start & ~start_d;

  always_comb begin
    limit = '1;
    case (state)
      S_CLEAR:                         limit = L_CLEAR;
      S_OPPRE:                         limit = L_OP_PRE;
      S_OP:                            limit = L_OP;
      S_OPPOST:                        limit = L_OP_POST;
      S_SET1, S_SET2, S_SET3, S_SET4:  limit = L_SETTLE;
      S_ATS1, S_ATS2:                  limit = L_ATS;
      S_NT:                            limit = L_NT;
      S_WTT, S_WLD:                    limit = L_TAPE_TO;
      default:                         limit = '1;
    endcase
  end

  assign count_done = bus.tick_ms && (cnt == limit);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_GO, S_FAULT: if (start_rise) state_n = S_CLEAR;
      S_WTT: begin
        if (fall_seen || tape_fall) state_n = S_SET2;
        else if (count_done)        state_n = S_FAULT;
      end
      S_WLD: begin
        if (fall_seen || tape_fall) state_n = S_SET4;
        else if (count_done)        state_n = S_FAULT;
      end
      // Every timed state is followed by its numeric successor.
      default: if (count_done) state_n = state_t'(state + 4'd1);
    endcase
    if (bus.abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= S_IDLE;
    else             state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)                     cnt <= '0;
    else if (state_n != state)           cnt <= '0;
    else if (bus.tick_ms && cnt != '1)   cnt <= cnt + CW'(1);
  end

  // A fall seen while the ATS pulse is still out must survive into the wait state.
  assign entering_ats = (state_n != state) && (state_n == S_ATS1 || state_n == S_ATS2);
  assign fall_watch   = (state == S_ATS1) || (state == S_WTT) ||
                        (state == S_ATS2) || (state == S_WLD);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)                   fall_seen <= 1'b0;
    else if (entering_ats)             fall_seen <= 1'b0;
    else if (fall_watch && tape_fall)  fall_seen <= 1'b1;
  end

  always_comb begin
    clear_d = 1'b0;
    op_d    = 1'b0;
    no_op_d = 1'b1;
    ats_d   = 1'b0;
    nt_d    = 1'b0;
    go_d    = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    busy_d  = (state >= S_CLEAR) && (state <= S_SET4);
    case (state)
      S_CLEAR:          clear_d = 1'b1;
      S_OPPRE, S_OPPOST: no_op_d = 1'b0;
      S_OP: begin
        no_op_d = 1'b0;
        op_d    = 1'b1;
      end
      S_ATS1, S_ATS2:   ats_d = 1'b1;
      S_NT:             nt_d  = 1'b1;
      S_GO: begin
        go_d   = 1'b1;
        done_d = 1'b1;
      end
      S_FAULT:          fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      clear_q    <= 1'b0;
      no_clear_q <= 1'b1;
      op_q       <= 1'b0;
      no_op_q    <= 1'b1;
      ats_q      <= 1'b0;
      nt_q       <= 1'b0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      phase_q    <= 4'd0;
    end else begin
      clear_q    <= clear_d;
      no_clear_q <= ~clear_d;
      op_q       <= op_d;
      no_op_q    <= no_op_d;
      ats_q      <= ats_d;
      nt_q       <= nt_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      phase_q    <= state;
    end
  end

  assign bus.PWR_CLEAR           = clear_q;
  assign bus.PWR_NO_CLEAR        = no_clear_q;
  assign bus.PWR_OP              = op_q;
  assign bus.PWR_NO_OP           = no_op_q;
  assign bus.PWR_AUTO_TAPE_START = ats_q;
  assign bus.PWR_NT              = nt_q;
  assign bus.SW_GO               = go_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.fault               = fault_q;
  assign bus.phase               = phase_q;

endmodule
